// File: rtl/sel_n_pipe_pkg.sv
// Shared constants for the registered priority selector: the default
// datapath word width and the storage-occupancy state encoding.
package sel_n_pipe_pkg;

    // Default datapath word width
    localparam int WORD = 32;

    // Storage occupancy: nothing held, main register only, main plus skid
    typedef logic [1:0] selp_state_t;

    localparam selp_state_t SELP_EMPTY = 2'd0;
    localparam selp_state_t SELP_ONE   = 2'd1;
    localparam selp_state_t SELP_TWO   = 2'd2;

endpackage

// File: rtl/sel_n_pipe_prio_enc.sv
// Highest-index-wins priority encoder. Purely combinational so it can be
// shared with other users such as the hazard unit.
module prio_enc_n #(
    parameter int NUM_IN = 4,
    parameter int IDX_W  = $clog2(NUM_IN)
) (
    input  logic [NUM_IN-1:0] req,
    output logic [IDX_W-1:0]  idx,
    output logic              none
);

    // Scan upward so the last asserted bit seen, the highest one, wins
    always_comb begin
        idx  = '0;
        none = 1'b1;
        for (int k = 0; k < NUM_IN; k++) begin
            if (req[k]) begin
                idx  = IDX_W'(k);
                none = 1'b0;
            end
        end
    end

endmodule

// File: rtl/sel_n_pipe.sv
// Registered N-way priority selector with a valid/ready handshake on both
// sides. A main register drives the outputs and a skid register absorbs the
// one extra set that can arrive while in_ready is still high from a flop.
module sel_n_pipe
    import sel_n_pipe_pkg::*;
#(
    parameter int WIDTH  = WORD,
    parameter int NUM_IN = 4,
    parameter int IDX_W  = $clog2(NUM_IN)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [NUM_IN-1:0]       req,
    input  logic [NUM_IN*WIDTH-1:0] in_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [WIDTH-1:0]        out_data,
    output logic [IDX_W-1:0]        out_idx,
    output logic                    out_none
);

    logic [IDX_W-1:0] sel_idx;
    logic             sel_none;
    logic [WIDTH-1:0] sel_data;

    selp_state_t      state;
    selp_state_t      state_nxt;
    logic             in_ready_q;

    logic [WIDTH-1:0] m_data;
    logic [IDX_W-1:0] m_idx;
    logic             m_none;
    logic [WIDTH-1:0] s_data;
    logic [IDX_W-1:0] s_idx;
    logic             s_none;

    logic             in_xfer;
    logic             out_xfer;

    prio_enc_n #(
        .NUM_IN (NUM_IN),
        .IDX_W  (IDX_W)
    ) u_prio_enc (
        .req  (req),
        .idx  (sel_idx),
        .none (sel_none)
    );

    // Pick the winning word; an empty request vector yields zero
    always_comb begin
        sel_data = '0;
        for (int k = 0; k < NUM_IN; k++) begin
            if (!sel_none && (sel_idx == IDX_W'(k))) begin
                sel_data = in_data[k*WIDTH +: WIDTH];
            end
        end
    end

    assign out_valid = (state != SELP_EMPTY);
    assign in_ready  = in_ready_q;
    assign in_xfer   = in_valid && in_ready_q;
    assign out_xfer  = out_valid && out_ready;

    // Occupancy transitions; TWO never sees an input transfer because in_ready is low
    always_comb begin
        state_nxt = state;
        case (state)
            SELP_EMPTY: begin
                if (in_xfer) begin
                    state_nxt = SELP_ONE;
                end
            end
            SELP_ONE: begin
                if (in_xfer && !out_xfer) begin
                    state_nxt = SELP_TWO;
                end else if (!in_xfer && out_xfer) begin
                    state_nxt = SELP_EMPTY;
                end
            end
            SELP_TWO: begin
                if (out_xfer) begin
                    state_nxt = SELP_ONE;
                end
            end
            default: begin
                state_nxt = SELP_EMPTY;
            end
        endcase
    end

    // State, registered in_ready and the M/S storage, all with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= SELP_EMPTY;
            in_ready_q <= 1'b1;
            m_data     <= '0;
            m_idx      <= '0;
            m_none     <= 1'b1;
            s_data     <= '0;
            s_idx      <= '0;
            s_none     <= 1'b1;
        end else begin
            state      <= state_nxt;
            in_ready_q <= (state_nxt != SELP_TWO);
            case (state)
                SELP_EMPTY: begin
                    if (in_xfer) begin
                        m_data <= sel_data;
                        m_idx  <= sel_idx;
                        m_none <= sel_none;
                    end
                end
                SELP_ONE: begin
                    if (in_xfer && out_xfer) begin
                        m_data <= sel_data;
                        m_idx  <= sel_idx;
                        m_none <= sel_none;
                    end else if (in_xfer) begin
                        s_data <= sel_data;
                        s_idx  <= sel_idx;
                        s_none <= sel_none;
                    end
                end
                SELP_TWO: begin
                    if (out_xfer) begin
                        m_data <= s_data;
                        m_idx  <= s_idx;
                        m_none <= s_none;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign out_data = m_data;
    assign out_idx  = m_idx;
    assign out_none = m_none;

endmodule

// File: tb/tb_sel_n_pipe.sv
// Bench for sel_n_pipe: directed scenarios plus randomized traffic, checked
// every cycle against a queue-based model of the selector pipeline.
module tb_sel_n_pipe;
    import sel_n_pipe_pkg::*;

    localparam int WIDTH  = WORD;
    localparam int NUM_IN = 4;
    localparam int IDX_W  = 2;

    logic                    clk = 1'b0;
    logic                    rst = 1'b1;
    logic                    in_valid = 1'b0;
    logic                    out_ready = 1'b0;
    logic [NUM_IN-1:0]       req = '0;
    logic [NUM_IN*WIDTH-1:0] in_data = '0;
    logic                    in_ready;
    logic                    out_valid;
    logic [WIDTH-1:0]        out_data;
    logic [IDX_W-1:0]        out_idx;
    logic                    out_none;

    typedef struct {
        logic [WIDTH-1:0] data;
        logic [IDX_W-1:0] idx;
        logic             none;
    } set_t;

    set_t q[$];
    int   vectors = 0;
    int   miscompares = 0;
    int   outCount = 0;
    bit   wasReset = 1'b0;

    sel_n_pipe #(
        .WIDTH  (WIDTH),
        .NUM_IN (NUM_IN)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .req       (req),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_idx   (out_idx),
        .out_none  (out_none)
    );

    always #5 clk = ~clk;

    // Reference selection: highest asserted request wins, none gives zero
    function automatic set_t selectRef(logic [NUM_IN-1:0] r, logic [NUM_IN*WIDTH-1:0] d);
        set_t s;
        bit   found;
        s.data = '0;
        s.idx  = '0;
        s.none = 1'b1;
        found  = 1'b0;
        for (int k = NUM_IN - 1; k >= 0; k--) begin
            if (r[k] && !found) begin
                found  = 1'b1;
                s.data = d[k*WIDTH +: WIDTH];
                s.idx  = IDX_W'(k);
                s.none = 1'b0;
            end
        end
        return s;
    endfunction

    task automatic check(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
        end
    endtask

    // Advance the model across one rising edge using its own occupancy
    task automatic modelEdge();
        bit inX;
        bit outX;
        if (rst) begin
            q.delete();
            wasReset = 1'b1;
        end else begin
            wasReset = 1'b0;
            inX  = in_valid && (q.size() < 2);
            outX = (q.size() > 0) && out_ready;
            if (outX) begin
                void'(q.pop_front());
                outCount++;
            end
            if (inX) begin
                q.push_back(selectRef(req, in_data));
            end
        end
    endtask

    // Compare every DUT output against the model state
    task automatic checkOutput();
        check("in_ready", {31'b0, in_ready}, {31'b0, (q.size() < 2)});
        check("out_valid", {31'b0, out_valid}, {31'b0, (q.size() > 0)});
        if (q.size() > 0) begin
            check("out_data", out_data, q[0].data);
            check("out_idx", {30'b0, out_idx}, {30'b0, q[0].idx});
            check("out_none", {31'b0, out_none}, {31'b0, q[0].none});
        end else if (wasReset) begin
            check("rst_data", out_data, '0);
            check("rst_idx", {30'b0, out_idx}, '0);
            check("rst_none", {31'b0, out_none}, 32'd1);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        modelEdge();
        @(negedge clk);
        checkOutput();
    endtask

    task automatic applyStimulus(input logic v, input logic [NUM_IN-1:0] r, input logic ordy);
        in_valid  = v;
        req       = r;
        out_ready = ordy;
    endtask

    function automatic logic [NUM_IN*WIDTH-1:0] kPattern();
        logic [NUM_IN*WIDTH-1:0] d;
        for (int k = 0; k < NUM_IN; k++) begin
            d[k*WIDTH +: WIDTH] = 32'h1000_0000 + WIDTH'(k);
        end
        return d;
    endfunction

    initial begin
        int base;

        // Reset held two cycles with in_valid high
        in_data = kPattern();
        applyStimulus(1'b1, 4'b1111, 1'b1);
        rst = 1'b1;
        cycle();
        cycle();
        check("lit_rst_valid", {31'b0, out_valid}, 32'd0);
        check("lit_rst_ready", {31'b0, in_ready}, 32'd1);
        check("lit_rst_none", {31'b0, out_none}, 32'd1);
        check("lit_rst_data", out_data, 32'd0);
        rst = 1'b0;

        // Priority, also exercising simultaneous in/out transfer in ONE
        applyStimulus(1'b1, 4'b1010, 1'b1);
        cycle();
        check("lit_prio1010_data", out_data, 32'h1000_0003);
        check("lit_prio1010_idx", {30'b0, out_idx}, 32'd3);
        applyStimulus(1'b1, 4'b0011, 1'b1);
        cycle();
        check("lit_prio0011_data", out_data, 32'h1000_0001);
        check("lit_prio0011_idx", {30'b0, out_idx}, 32'd1);
        check("lit_simul_ready", {31'b0, in_ready}, 32'd1);
        applyStimulus(1'b1, 4'b0000, 1'b1);
        cycle();
        check("lit_prio0000_data", out_data, 32'd0);
        check("lit_prio0000_none", {31'b0, out_none}, 32'd1);
        applyStimulus(1'b0, 4'b0000, 1'b1);
        cycle();

        // Streaming: 8 back-to-back sets
        base = outCount;
        for (int i = 0; i < 8; i++) begin
            in_data = {$urandom, $urandom, $urandom, $urandom};
            applyStimulus(1'b1, NUM_IN'($urandom), 1'b1);
            cycle();
            check("lit_stream_ready", {31'b0, in_ready}, 32'd1);
        end
        applyStimulus(1'b0, 4'b0000, 1'b1);
        cycle();
        check("lit_stream_count", outCount - base, 32'd8);

        // Backpressure: A, B accepted, C held off
        in_data = kPattern();
        applyStimulus(1'b1, 4'b0001, 1'b0);
        cycle();
        applyStimulus(1'b1, 4'b0010, 1'b0);
        cycle();
        check("lit_bp_ready_low", {31'b0, in_ready}, 32'd0);
        applyStimulus(1'b1, 4'b0100, 1'b0);
        for (int i = 0; i < 3; i++) begin
            cycle();
            check("lit_bp_stall_data", out_data, 32'h1000_0000);
        end
        out_ready = 1'b1;
        cycle();
        check("lit_bp_B", out_data, 32'h1000_0001);
        cycle();
        check("lit_bp_C", out_data, 32'h1000_0002);
        applyStimulus(1'b0, 4'b0000, 1'b1);
        cycle();
        check("lit_bp_drained", {31'b0, out_valid}, 32'd0);

        // Reset while two sets are held
        applyStimulus(1'b1, 4'b1000, 1'b0);
        cycle();
        cycle();
        rst = 1'b1;
        applyStimulus(1'b0, 4'b0000, 1'b0);
        cycle();
        check("lit_midrst_valid", {31'b0, out_valid}, 32'd0);
        check("lit_midrst_ready", {31'b0, in_ready}, 32'd1);
        rst = 1'b0;
        applyStimulus(1'b1, 4'b0100, 1'b1);
        cycle();
        check("lit_midrst_X", out_data, 32'h1000_0002);
        applyStimulus(1'b0, 4'b0000, 1'b1);
        cycle();
        check("lit_midrst_alone", {31'b0, out_valid}, 32'd0);

        // Randomized traffic with occasional reset
        for (int i = 0; i < 3000; i++) begin
            in_data = {$urandom, $urandom, $urandom, $urandom};
            rst = ($urandom_range(0, 199) == 0);
            applyStimulus(($urandom_range(0, 3) != 0), NUM_IN'($urandom),
                          ($urandom_range(0, 9) < 7));
            cycle();
        end
        rst = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
